lct_deadtime_filter: RTL and testbench
======================================

// Module: lct_deadtime_filter
// PURPOSE
//  Downstream of the ALCT pattern finder/promoter. Takes the best (h*) and second (l*) LCT each BX,
//  suppresses repeats of a track inside a programmable dead-time window (±1 key wire, same/lower
//  quality), reorders survivors into lct0/lct1, stamps a 12-bit BXN and registers the result for
//  the TMB output mux. Shower bits pass through aligned to the LCT latency.
// PARAMETERS
//  NKEY    112   number of key wire groups (key field 7 bits)
//  MAX_BXN 3564  BX counter modulus (counts 0..MAX_BXN-1)
//  NREC    2     number of dead-time records
// PORTS
//  clk            in   1   system clock (40 MHz)
//  rst            in   1   synchronous active-high reset
//  hv,hp,hnp,hfap in   1,2,7,1  best LCT: valid, quality, key wire, accel flag
//  lv,lp,lnp,lfap in   1,2,7,1  second LCT: same fields
//  shower_int     in   2   HMT shower bits, same BX as LCT inputs
//  dead_time      in   4   dead-time in BX; 0 = filter disabled
//  bc0            in   1   bunch-crossing-zero strobe
//  bxn_offset     in   12  BXN load value on bc0 (must be < MAX_BXN)
//  trig_stop      in   1   halt: outputs zeroed, records cleared
//  lct0_v,lct0_q,lct0_key,lct0_fa  out 1,2,7,1  first output LCT
//  lct1_v,lct1_q,lct1_key,lct1_fa  out 1,2,7,1  second output LCT
//  lct_bxn        out  12  BXN of the BX the outputs belong to
//  shower_out     out  2   shower_int delayed 1 clk
//  supp_cnt       out  16  suppressed-LCT counter, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, records empty, BXN counter 0, supp_cnt 0.
//  - Latency: exactly 1 clk, inputs at edge N -> outputs valid after edge N+1; shower_out same.
//  - Record r: {busy, key[6:0], q[1:0], cnt[3:0]}. Candidate C matches r when busy &&
//    |C.key - r.key| <= 1 && C.q <= r.q. Matched candidate is suppressed (supp_cnt +1 each,
//    saturate at 16'hFFFF; +2 in one clk if both suppressed).
//  - Higher-quality candidate within ±1 key is NOT suppressed; it overwrites that record.
//  - Acceptance: each unsuppressed valid candidate loads a record {1,key,q,dead_time}; target
//    = matching record (overwrite), else free record (lowest index), else record with smallest
//    cnt (lowest index on tie). h processed before l; l checked against records as updated by h
//    in the same clk (l at ±1 of accepted h with q <= h.q is suppressed).
//  - Countdown: each clk, busy records with no load do cnt-1; cnt 1->0 clears busy.
//    Record loaded in clk N filters from clk N+1; dead_time=1 blocks exactly one following BX.
//  - dead_time==0: no suppression, no loads; records cleared; pure 1-clk pass-through.
//  - Ordering: if h survives -> lct0=h, lct1=l (if l survives). If h suppressed and l survives
//    -> lct0=l, lct1=0. Invalid candidates never load, never count. Output fields zero when v=0.
//  - BXN: increments every clk, wraps MAX_BXN-1 -> 0. bc0 at clk N: counter = bxn_offset after
//    edge N. lct_bxn = counter value registered with the inputs (same BX as the LCT).
//  - trig_stop=1: lct*/shower_out zero next clk, records cleared, supp_cnt held, BXN keeps running.
//  - dead_time change mid-window: running cnt unaffected; new value applies to next load only.
//  - rst mid-operation: overrides everything including bc0 and trig_stop.
// STRUCTURE
//  - Shared package alct_lct_pkg: lct_t struct {v,q[1:0],key[6:0],fa}, KEY_W=7, Q_W=2,
//    BXN_W=12, MAX_BXN constant.
//  - One sub-module: lct_dt_record (single record: match compare, load, countdown);
//    NREC instances; selection/ordering, BXN counter and counters in top.
// TESTING
//  1 dead_time=3; h {q=3,key=40} at BX0 and BX1..4 -> out BX0 only; BX1-3 suppressed, BX4
//    passes; supp_cnt=3.
//  2 dead_time=5; h {q=1,key=20} BX0, h {q=3,key=21} BX2 -> both out; record now key21 q3.
//  3 same clk h {q=2,key=50}, l {q=2,key=51}, dead_time=2 -> lct0=key50, lct1=0, supp_cnt=1;
//    h {q=1,key=90}, l {q=2,key=10} with record key90 q2 busy -> lct0=key10, lct1=0.
//  4 dead_time=8; keys 10,30,60 accepted at BX0,1,2 -> key60 replaces key10 record; key10 at
//    BX3 passes, key30 at BX3 suppressed.
//  5 counter at 3563 -> 0 next clk; bc0 with bxn_offset=100 -> 100, then 101; LCT in bc0 BX
//    tagged with pre-load value.
//  6 dead_time=0 -> any repeat passes, supp_cnt unchanged; trig_stop pulse mid-window -> outputs
//    0 that clk, next identical LCT passes (records cleared); rst -> all outputs/counters 0.

Source files
------------

// File: rtl/alct_lct_pkg.sv
// ============================================================================
//  Module      : alct_lct_pkg
//  Description : Shared LCT field widths, BX counter modulus, LCT struct and
//                the +-1 key-wire adjacency helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alct_lct_pkg;

    localparam int KEY_W   = 7;
    localparam int Q_W     = 2;
    localparam int BXN_W   = 12;
    localparam int CNT_W   = 4;
    localparam int MAX_BXN = 3564;

    typedef struct packed {
        logic             v;
        logic [Q_W-1:0]   q;
        logic [KEY_W-1:0] key;
        logic             fa;
    } lct_t;

    // Widened by one bit so keys at the ends of the range never alias.
    function automatic logic key_near(input logic [KEY_W-1:0] a,
                                      input logic [KEY_W-1:0] b);
        logic [KEY_W:0] wa;
        logic [KEY_W:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa == wb) || (wa == wb + 1'b1) || (wb == wa + 1'b1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lct_deadtime_filter_if.sv
// ============================================================================
//  Module      : lct_deadtime_filter_if
//  Description : LCT candidate inputs, control and filtered LCT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lct_deadtime_filter_if;
    import alct_lct_pkg::*;

    logic             hv;
    logic [Q_W-1:0]   hp;
    logic [KEY_W-1:0] hnp;
    logic             hfap;
    logic             lv;
    logic [Q_W-1:0]   lp;
    logic [KEY_W-1:0] lnp;
    logic             lfap;
    logic [1:0]       shower_int;
    logic [CNT_W-1:0] dead_time;
    logic             bc0;
    logic [BXN_W-1:0] bxn_offset;
    logic             trig_stop;

    logic             lct0_v;
    logic [Q_W-1:0]   lct0_q;
    logic [KEY_W-1:0] lct0_key;
    logic             lct0_fa;
    logic             lct1_v;
    logic [Q_W-1:0]   lct1_q;
    logic [KEY_W-1:0] lct1_key;
    logic             lct1_fa;
    logic [BXN_W-1:0] lct_bxn;
    logic [1:0]       shower_out;
    logic [15:0]      supp_cnt;

    modport master (
        output hv, hp, hnp, hfap, lv, lp, lnp, lfap,
        output shower_int, dead_time, bc0, bxn_offset, trig_stop,
        input  lct0_v, lct0_q, lct0_key, lct0_fa,
        input  lct1_v, lct1_q, lct1_key, lct1_fa,
        input  lct_bxn, shower_out, supp_cnt
    );

    modport slave (
        input  hv, hp, hnp, hfap, lv, lp, lnp, lfap,
        input  shower_int, dead_time, bc0, bxn_offset, trig_stop,
        output lct0_v, lct0_q, lct0_key, lct0_fa,
        output lct1_v, lct1_q, lct1_key, lct1_fa,
        output lct_bxn, shower_out, supp_cnt
    );

endinterface

`default_nettype wire

// File: rtl/lct_dt_record.sv
// ============================================================================
//  Module      : lct_dt_record
//  Description : One dead-time record: adjacency/quality match, load, countdown.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lct_dt_record
    import alct_lct_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] dead_time_i,
    input  logic [KEY_W-1:0] h_key_i,
    input  logic [Q_W-1:0]   h_q_i,
    input  logic             load_h_i,
    input  logic [KEY_W-1:0] l_key_i,
    input  logic [Q_W-1:0]   l_q_i,
    input  logic             load_l_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             near_h_o,
    output logic             supp_h_o,
    output logic             post_busy_o,
    output logic [CNT_W-1:0] post_cnt_o,
    output logic             near_l_o,
    output logic             supp_l_o
);

    logic             busy_q, busy_d;
    logic [KEY_W-1:0] key_q,  key_d;
    logic [Q_W-1:0]   q_q,    q_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic [KEY_W-1:0] w_key_ph;
    logic [Q_W-1:0]   w_q_ph;

    // The l candidate sees this record as it will look after any h load.
    assign post_busy_o = busy_q | load_h_i;
    assign post_cnt_o  = load_h_i ? dead_time_i : cnt_q;
    assign w_key_ph    = load_h_i ? h_key_i : key_q;
    assign w_q_ph      = load_h_i ? h_q_i   : q_q;

    assign busy_o   = busy_q;
    assign cnt_o    = cnt_q;
    assign near_h_o = busy_q & key_near(h_key_i, key_q);
    assign supp_h_o = near_h_o & (h_q_i <= q_q);
    assign near_l_o = post_busy_o & key_near(l_key_i, w_key_ph);
    assign supp_l_o = near_l_o & (l_q_i <= w_q_ph);

    always_comb begin
        busy_d = busy_q;
        key_d  = key_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            busy_d = 1'b0;
            key_d  = '0;
            q_d    = '0;
            cnt_d  = '0;
        end else if (load_l_i) begin
            busy_d = 1'b1;
            key_d  = l_key_i;
            q_d    = l_q_i;
            cnt_d  = dead_time_i;
        end else if (load_h_i) begin
            busy_d = 1'b1;
            key_d  = h_key_i;
            q_d    = h_q_i;
            cnt_d  = dead_time_i;
        end else if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            key_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            key_q  <= key_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lct_deadtime_filter.sv
// ============================================================================
//  Module      : lct_deadtime_filter
//  Description : Dead-time repeat suppression, lct0/lct1 reordering, BXN stamp.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lct_deadtime_filter
    import alct_lct_pkg::*;
#(
    parameter int NKEY    = 112,
    parameter int MAX_BXN = alct_lct_pkg::MAX_BXN,
    parameter int NREC    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    lct_deadtime_filter_if.slave  bus
);

    lct_t             w_h, w_l;
    logic             w_clr, w_filt_en;
    logic [NREC-1:0]  w_busy, w_near_h, w_supp_h, w_post_busy, w_near_l, w_supp_l;
    logic [NREC-1:0]  w_load_h, w_load_l;
    logic [NREC-1:0][CNT_W-1:0] w_cnt, w_post_cnt;
    logic             w_h_supp, w_l_supp, w_h_surv, w_l_surv;
    logic [16:0]      w_supp_sum;

    lct_t             lct0_q, lct0_d, lct1_q, lct1_d;
    logic [BXN_W-1:0] bxn_q, bxn_d, lct_bxn_q, lct_bxn_d;
    logic [1:0]       shower_q, shower_d;
    logic [15:0]      supp_q, supp_d;

    // Adjacent record first (overwrite), then lowest free, then oldest.
    function automatic logic [NREC-1:0] pick_target(
        input logic [NREC-1:0]             near,
        input logic [NREC-1:0]             busy,
        input logic [NREC-1:0][CNT_W-1:0]  cnt
    );
        logic [NREC-1:0]  sel;
        logic             found;
        logic [CNT_W-1:0] best;
        int               bi;
        sel   = '0;
        found = 1'b0;
        best  = cnt[0];
        bi    = 0;
        for (int i = 0; i < NREC; i++) begin
            if (!found && near[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NREC; i++) begin
            if (!found && !busy[i]) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 1; i < NREC; i++) begin
                if (cnt[i] < best) begin
                    best = cnt[i];
                    bi   = i;
                end
            end
            for (int i = 0; i < NREC; i++) begin
                if (i == bi) sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_h     = '0;
        w_h.v   = bus.hv & ({1'b0, bus.hnp} < (KEY_W+1)'(NKEY));
        w_h.q   = w_h.v ? bus.hp   : '0;
        w_h.key = w_h.v ? bus.hnp  : '0;
        w_h.fa  = w_h.v ? bus.hfap : 1'b0;
        w_l     = '0;
        w_l.v   = bus.lv & ({1'b0, bus.lnp} < (KEY_W+1)'(NKEY));
        w_l.q   = w_l.v ? bus.lp   : '0;
        w_l.key = w_l.v ? bus.lnp  : '0;
        w_l.fa  = w_l.v ? bus.lfap : 1'b0;
    end

    assign w_clr     = bus.trig_stop | (bus.dead_time == '0);
    assign w_filt_en = ~w_clr;

    generate
        for (genvar gi = 0; gi < NREC; gi++) begin : g_rec
            lct_dt_record u_rec (
                .clk         (clk),
                .rst         (rst),
                .clr_i       (w_clr),
                .dead_time_i (bus.dead_time),
                .h_key_i     (w_h.key),
                .h_q_i       (w_h.q),
                .load_h_i    (w_load_h[gi]),
                .l_key_i     (w_l.key),
                .l_q_i       (w_l.q),
                .load_l_i    (w_load_l[gi]),
                .busy_o      (w_busy[gi]),
                .cnt_o       (w_cnt[gi]),
                .near_h_o    (w_near_h[gi]),
                .supp_h_o    (w_supp_h[gi]),
                .post_busy_o (w_post_busy[gi]),
                .post_cnt_o  (w_post_cnt[gi]),
                .near_l_o    (w_near_l[gi]),
                .supp_l_o    (w_supp_l[gi])
            );
        end
    endgenerate

    assign w_h_supp = w_filt_en & w_h.v & (|w_supp_h);
    assign w_l_supp = w_filt_en & w_l.v & (|w_supp_l);
    assign w_h_surv = w_h.v & ~w_h_supp;
    assign w_l_surv = w_l.v & ~w_l_supp;

    assign w_load_h = (w_filt_en & w_h_surv)
                    ? pick_target(w_near_h, w_busy, w_cnt) : '0;
    assign w_load_l = (w_filt_en & w_l_surv)
                    ? pick_target(w_near_l, w_post_busy, w_post_cnt) : '0;

    assign w_supp_sum = {1'b0, supp_q} + 17'(w_h_supp) + 17'(w_l_supp);

    always_comb begin
        lct0_d    = '0;
        lct1_d    = '0;
        lct_bxn_d = '0;
        shower_d  = '0;
        supp_d    = w_supp_sum[16] ? 16'hFFFF : w_supp_sum[15:0];
        if (!bus.trig_stop) begin
            lct_bxn_d = bxn_q;
            shower_d  = bus.shower_int;
            if (w_h_surv) begin
                lct0_d = w_h;
                lct1_d = w_l_surv ? w_l : '0;
            end else if (w_l_surv) begin
                lct0_d = w_l;
            end
        end
        if (bus.bc0) begin
            bxn_d = bus.bxn_offset;
        end else if (bxn_q == BXN_W'(MAX_BXN - 1)) begin
            bxn_d = '0;
        end else begin
            bxn_d = bxn_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lct0_q    <= '0;
            lct1_q    <= '0;
            lct_bxn_q <= '0;
            shower_q  <= '0;
            supp_q    <= '0;
            bxn_q     <= '0;
        end else begin
            lct0_q    <= lct0_d;
            lct1_q    <= lct1_d;
            lct_bxn_q <= lct_bxn_d;
            shower_q  <= shower_d;
            supp_q    <= supp_d;
            bxn_q     <= bxn_d;
        end
    end

    assign bus.lct0_v     = lct0_q.v;
    assign bus.lct0_q     = lct0_q.q;
    assign bus.lct0_key   = lct0_q.key;
    assign bus.lct0_fa    = lct0_q.fa;
    assign bus.lct1_v     = lct1_q.v;
    assign bus.lct1_q     = lct1_q.q;
    assign bus.lct1_key   = lct1_q.key;
    assign bus.lct1_fa    = lct1_q.fa;
    assign bus.lct_bxn    = lct_bxn_q;
    assign bus.shower_out = shower_q;
    assign bus.supp_cnt   = supp_q;

endmodule

`default_nettype wire

// File: tb/tb_lct_deadtime_filter.sv
// ============================================================================
//  Module      : tb_lct_deadtime_filter
//  Description : Directed self-checking bench for lct_deadtime_filter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lct_deadtime_filter;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   exp_supp;

    lct_deadtime_filter_if bus();

    lct_deadtime_filter #(
        .NKEY    (112),
        .MAX_BXN (3564),
        .NREC    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] L(input logic v, input logic [1:0] q,
                                      input logic [6:0] k, input logic fa);
        return {v, q, k, fa};
    endfunction

    function automatic logic [10:0] out0();
        return {bus.lct0_v, bus.lct0_q, bus.lct0_key, bus.lct0_fa};
    endfunction

    function automatic logic [10:0] out1();
        return {bus.lct1_v, bus.lct1_q, bus.lct1_key, bus.lct1_fa};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hv, input logic [1:0] hq, input logic [6:0] hk,
                         input logic hfa, input logic lv, input logic [1:0] lq,
                         input logic [6:0] lk);
        bus.hv   = hv;  bus.hp = hq; bus.hnp = hk; bus.hfap = hfa;
        bus.lv   = lv;  bus.lp = lq; bus.lnp = lk; bus.lfap = 1'b0;
    endtask

    task automatic flush();
        bus.dead_time = 4'd0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 3, 7'd33, 1, 1, 2, 7'd60);
        bus.shower_int = 2'b11; bus.dead_time = 4'd3;
        bus.bc0 = 1'b0; bus.bxn_offset = '0; bus.trig_stop = 1'b0;
        tick(); tick();
        checks++;
        if ({out0(), out1()} !== 22'd0) $display("FAIL reset_lct: got %h exp 0", {out0(), out1()});
        else passes++;
        checks++;
        if ({bus.lct_bxn, bus.shower_out, bus.supp_cnt} !== 30'd0)
            $display("FAIL reset_misc: bxn=%0d shower=%0d supp=%0d exp 0", bus.lct_bxn, bus.shower_out, bus.supp_cnt);
        else passes++;
        rst = 1'b0;
        bus.shower_int = 2'b00;
        flush();
    endtask

    task automatic test_repeat_suppress();
        flush();
        bus.dead_time = 4'd3;
        drive(1, 3, 7'd40, 1, 0, 0, 0);
        tick();
        checks++;
        if (out0() !== L(1, 3, 40, 1)) $display("FAIL t1_bx0: got %h exp %h", out0(), L(1, 3, 40, 1));
        else passes++;
        for (int bx = 1; bx <= 3; bx++) begin
            tick();
            exp_supp++;
            checks++;
            if (out0() !== 11'd0) $display("FAIL t1_bx%0d_supp: got %h exp 0", bx, out0());
            else passes++;
        end
        tick();
        checks++;
        if (out0() !== L(1, 3, 40, 1)) $display("FAIL t1_bx4: got %h exp %h", out0(), L(1, 3, 40, 1));
        else passes++;
        checks++;
        if (bus.supp_cnt !== 16'(exp_supp)) $display("FAIL t1_supp: got %0d exp %0d", bus.supp_cnt, exp_supp);
        else passes++;
    endtask

    task automatic test_quality_overwrite();
        flush();
        bus.dead_time = 4'd5;
        drive(1, 1, 7'd20, 0, 0, 0, 0);
        tick();
        checks++;
        if (out0() !== L(1, 1, 20, 0)) $display("FAIL t2_first: got %h exp %h", out0(), L(1, 1, 20, 0));
        else passes++;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 7'd21, 0, 0, 0, 0);
        tick();
        checks++;
        if (out0() !== L(1, 3, 21, 0)) $display("FAIL t2_higher_q: got %h exp %h", out0(), L(1, 3, 21, 0));
        else passes++;
        // key20 record must be gone: key19 q1 only adjoins key20
        drive(1, 1, 7'd19, 0, 0, 0, 0);
        tick();
        checks++;
        if (out0() !== L(1, 1, 19, 0)) $display("FAIL t2_overwritten: got %h exp %h", out0(), L(1, 1, 19, 0));
        else passes++;
    endtask

    task automatic test_same_clk();
        flush();
        bus.dead_time = 4'd2;
        drive(1, 2, 7'd50, 0, 1, 2, 7'd51);
        tick();
        exp_supp++;
        checks++;
        if ({out0(), out1()} !== {L(1, 2, 50, 0), 11'd0})
            $display("FAIL t3_h_vs_l: got %h exp %h", {out0(), out1()}, {L(1, 2, 50, 0), 11'd0});
        else passes++;
        checks++;
        if (bus.supp_cnt !== 16'(exp_supp)) $display("FAIL t3_supp: got %0d exp %0d", bus.supp_cnt, exp_supp);
        else passes++;
        flush();
        bus.dead_time = 4'd4;
        drive(1, 2, 7'd90, 0, 0, 0, 0);
        tick();
        drive(1, 1, 7'd90, 0, 1, 2, 7'd10);
        tick();
        exp_supp++;
        checks++;
        if ({out0(), out1()} !== {L(1, 2, 10, 0), 11'd0})
            $display("FAIL t3_promote_l: got %h exp %h", {out0(), out1()}, {L(1, 2, 10, 0), 11'd0});
        else passes++;
        drive(1, 3, 7'd70, 0, 1, 1, 7'd30);
        tick();
        checks++;
        if ({out0(), out1()} !== {L(1, 3, 70, 0), L(1, 1, 30, 0)})
            $display("FAIL t3_both: got %h exp %h", {out0(), out1()}, {L(1, 3, 70, 0), L(1, 1, 30, 0)});
        else passes++;
    endtask

    task automatic test_replace_oldest();
        flush();
        bus.dead_time = 4'd8;
        drive(1, 1, 7'd10, 0, 0, 0, 0); tick();
        drive(1, 1, 7'd30, 0, 0, 0, 0); tick();
        drive(1, 1, 7'd60, 0, 0, 0, 0); tick();
        checks++;
        if (out0() !== L(1, 1, 60, 0)) $display("FAIL t4_key60: got %h exp %h", out0(), L(1, 1, 60, 0));
        else passes++;
        drive(1, 1, 7'd30, 0, 1, 1, 7'd10);
        tick();
        exp_supp++;
        checks++;
        if ({out0(), out1()} !== {L(1, 1, 10, 0), 11'd0})
            $display("FAIL t4_evict: got %h exp %h", {out0(), out1()}, {L(1, 1, 10, 0), 11'd0});
        else passes++;
        checks++;
        if (bus.supp_cnt !== 16'(exp_supp)) $display("FAIL t4_supp: got %0d exp %0d", bus.supp_cnt, exp_supp);
        else passes++;
    endtask

    task automatic test_bxn();
        flush();
        bus.bc0 = 1'b1; bus.bxn_offset = 12'd3562;
        tick();
        bus.bc0 = 1'b0;
        tick();
        checks++;
        if (bus.lct_bxn !== 12'd3562) $display("FAIL t5_load: got %0d exp 3562", bus.lct_bxn);
        else passes++;
        tick();
        checks++;
        if (bus.lct_bxn !== 12'd3563) $display("FAIL t5_top: got %0d exp 3563", bus.lct_bxn);
        else passes++;
        tick();
        checks++;
        if (bus.lct_bxn !== 12'd0) $display("FAIL t5_wrap: got %0d exp 0", bus.lct_bxn);
        else passes++;
        bus.bc0 = 1'b1; bus.bxn_offset = 12'd100;
        drive(1, 2, 7'd5, 0, 0, 0, 0);
        tick();
        bus.bc0 = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({out0(), bus.lct_bxn} !== {L(1, 2, 5, 0), 12'd1})
            $display("FAIL t5_bc0_bx: got %h exp %h", {out0(), bus.lct_bxn}, {L(1, 2, 5, 0), 12'd1});
        else passes++;
        tick();
        checks++;
        if (bus.lct_bxn !== 12'd100) $display("FAIL t5_offset: got %0d exp 100", bus.lct_bxn);
        else passes++;
        tick();
        checks++;
        if (bus.lct_bxn !== 12'd101) $display("FAIL t5_inc: got %0d exp 101", bus.lct_bxn);
        else passes++;
    endtask

    task automatic test_disable_stop_rst();
        flush();
        drive(1, 3, 7'd40, 0, 0, 0, 0);
        bus.shower_int = 2'b10;
        tick();
        checks++;
        if ({out0(), bus.shower_out} !== {L(1, 3, 40, 0), 2'b10})
            $display("FAIL t6_dt0_a: got %h exp %h", {out0(), bus.shower_out}, {L(1, 3, 40, 0), 2'b10});
        else passes++;
        bus.shower_int = 2'b00;
        tick();
        checks++;
        if ({out0(), bus.supp_cnt} !== {L(1, 3, 40, 0), 16'(exp_supp)})
            $display("FAIL t6_dt0_b: got %h exp %h", {out0(), bus.supp_cnt}, {L(1, 3, 40, 0), 16'(exp_supp)});
        else passes++;
        bus.dead_time = 4'd3;
        tick();
        bus.trig_stop = 1'b1; bus.shower_int = 2'b11;
        tick();
        checks++;
        if ({out0(), bus.shower_out, bus.supp_cnt} !== {11'd0, 2'b00, 16'(exp_supp)})
            $display("FAIL t6_stop: got %h exp %h", {out0(), bus.shower_out, bus.supp_cnt}, {11'd0, 2'b00, 16'(exp_supp)});
        else passes++;
        bus.trig_stop = 1'b0; bus.shower_int = 2'b00;
        tick();
        checks++;
        if (out0() !== L(1, 3, 40, 0)) $display("FAIL t6_after_stop: got %h exp %h", out0(), L(1, 3, 40, 0));
        else passes++;
        rst = 1'b1; bus.bc0 = 1'b1; bus.bxn_offset = 12'd77; bus.trig_stop = 1'b1;
        tick();
        exp_supp = 0;
        checks++;
        if ({out0(), out1(), bus.lct_bxn, bus.supp_cnt} !== 50'd0)
            $display("FAIL t6_rst: got %h exp 0", {out0(), out1(), bus.lct_bxn, bus.supp_cnt});
        else passes++;
        rst = 1'b0; bus.bc0 = 1'b0; bus.trig_stop = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++;
        if (bus.lct_bxn !== 12'd1) $display("FAIL t6_post_rst_bxn: got %0d exp 1", bus.lct_bxn);
        else passes++;
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        exp_supp = 0;
        rst      = 1'b1;
        test_reset();
        test_repeat_suppress();
        test_quality_overwrite();
        test_same_clk();
        test_replace_oldest();
        test_bxn();
        test_disable_stop_rst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
